// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared definitions for the async FIFO write-port arbiter.
//   arb_state_e : arbiter FSM encoding (idle = 0, grant = 1)
//   clog2       : ceiling log2 for constant width calculations
//   id_width    : width of a requester index (never below 1 bit)
package async_fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_rr.sv
// Combinational round-robin search: returns the first requester with valid set,
// scanning ptr_i, ptr_i+1, ... modulo NReq.
//   valid_i     : per-requester request vector
//   ptr_i       : highest-priority requester for this search
//   winner_o    : index of the selected requester (0 when none valid)
//   any_valid_o : at least one requester is valid
module async_fifo_wr_arbiter_rr
  import async_fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdW = id_width(NReq)
) (
  input  logic [NReq-1:0] valid_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [IdW-1:0]  winner_o,
  output logic            any_valid_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int unsigned SumW = IdW + 1;

  logic [SumW-1:0] sum;
  logic            found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    sum      = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      sum = {1'b0, ptr_i} + SumW'(i);
      if (sum >= SumW'(NReq)) sum = sum - SumW'(NReq);
      if (!found && valid_i[sum[IdW-1:0]]) begin
        found    = 1'b1;
        winner_o = sum[IdW-1:0];
      end
    end
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NReq requesters.
// Lives entirely in the FIFO write-clock domain.
//   clk_i          : write-side clock
//   arstn_ni       : asynchronous active-low reset
//   req_valid_i    : per-requester beat valid
//   req_data_i     : requester i data at [i*Width +: Width]
//   req_last_i     : last beat of packet (only used when PktMode = 1)
//   req_ready_o    : per-requester ready, one-hot or zero
//   fifo_wr_en_o   : FIFO write enable (never high while fifo_wr_full_i)
//   fifo_wr_data_o : FIFO write data, muxed from the granted requester
//   fifo_wr_full_i : FIFO full flag
//   grant_id_o     : current or most recent granted requester
//   busy_o         : high while a grant is held
// PktMode = 1 holds a grant until the last beat; PktMode = 0 releases after MaxBurst
// beats or as soon as the granted requester drops valid.
module async_fifo_wr_arbiter
  import async_fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NReq     = 4,
  parameter int unsigned Width    = 8,
  parameter bit          PktMode  = 1'b1,
  parameter int unsigned MaxBurst = 4,
  localparam int unsigned IdW     = id_width(NReq)
) (
  input  logic                  clk_i,
  input  logic                  arstn_ni,
  input  logic [NReq-1:0]       req_valid_i,
  input  logic [NReq*Width-1:0] req_data_i,
  input  logic [NReq-1:0]       req_last_i,
  output logic [NReq-1:0]       req_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [Width-1:0]      fifo_wr_data_o,
  input  logic                  fifo_wr_full_i,
  output logic [IdW-1:0]        grant_id_o,
  output logic                  busy_o
);

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;

  logic [IdW-1:0] winner;
  logic           any_valid;
  logic           gnt_valid;
  logic           beat;
  logic           release_grant;

  logic [Width-1:0] data_arr [NReq];

  for (genvar i = 0; i < NReq; i++) begin : g_unpack
    assign data_arr[i] = req_data_i[i*Width +: Width];
  end

  async_fifo_wr_arbiter_rr #(
    .NReq(NReq)
  ) u_rr (
    .valid_i    (req_valid_i),
    .ptr_i      (rr_ptr_q),
    .winner_o   (winner),
    .any_valid_o(any_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready_o   = '0;
    beat          = 1'b0;
    release_grant = 1'b0;
    gnt_valid     = req_valid_i[grant_id_q];

    unique case (state_q)
      StIdle: begin
        // Arbitration only; no beat moves in this cycle.
        if (any_valid) begin
          grant_id_d = winner;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        req_ready_o[grant_id_q] = ~fifo_wr_full_i;
        beat = gnt_valid & ~fifo_wr_full_i;
        if (PktMode) begin
          // A valid gap mid-packet keeps the grant; only a last beat releases.
          release_grant = beat & req_last_i[grant_id_q];
          if (beat && (beat_cnt_q != 8'hFF)) beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          release_grant = ~gnt_valid |
                          (beat & ((32'(beat_cnt_q) + 32'd1) == MaxBurst));
          if (beat) beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (release_grant) begin
          state_d = StIdle;
          if (grant_id_q == IdW'(NReq - 1)) rr_ptr_d = '0;
          else                              rr_ptr_d = grant_id_q + IdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    fifo_wr_en_o = beat;
  end

  always_ff @(posedge clk_i or negedge arstn_ni) begin
    if (!arstn_ni) begin
      state_q    <= StIdle;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign fifo_wr_data_o = data_arr[grant_id_q];
  assign grant_id_o     = grant_id_q;
  assign busy_o         = (state_q == StGrant);

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter. Three instances share one reset:
//   k=0 packet mode, k=1 burst mode MaxBurst=4, k=2 burst mode MaxBurst=1.
// Per-requester script queues feed a driver; each beat presented is pushed onto an
// expected queue and popped by a negedge monitor that also checks the grant rules.
module tb_async_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int NK = 3;
  localparam int MB = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic arstn;

  logic [NR-1:0]   valid   [NK];
  logic [NR*W-1:0] data    [NK];
  logic [NR-1:0]   last    [NK];
  logic [NR-1:0]   ready   [NK];
  logic            wr_en   [NK];
  logic [W-1:0]    wr_data [NK];
  logic            full    [NK];
  logic [1:0]      gid     [NK];
  logic            busy    [NK];

  beat_t        script_q [NK*NR][$];
  logic [W-1:0] exp_q    [NK*NR][$];
  logic [W-1:0] log_q    [NK][$];
  logic [1:0]   gseq_q   [NK][$];
  int           bcnt_q   [NK][$];
  logic [NR-1:0] acc     [NK];
  bit bubble_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  initial forever #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    async_fifo_wr_arbiter #(
      .NReq    (NR),
      .Width   (W),
      .PktMode (k == 0),
      .MaxBurst((k == 2) ? 1 : MB)
    ) u_dut (
      .clk_i         (clk),
      .arstn_ni      (arstn),
      .req_valid_i   (valid[k]),
      .req_data_i    (data[k]),
      .req_last_i    (last[k]),
      .req_ready_o   (ready[k]),
      .fifo_wr_en_o  (wr_en[k]),
      .fifo_wr_data_o(wr_data[k]),
      .fifo_wr_full_i(full[k]),
      .grant_id_o    (gid[k]),
      .busy_o        (busy[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Driver: beats are held until accepted; the next scripted beat may follow at once.
  initial begin
    for (int k = 0; k < NK; k++) begin
      valid[k] = '0;
      data[k]  = '0;
      last[k]  = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NK; k++) begin
        for (int r = 0; r < NR; r++) begin
          int q;
          beat_t b;
          q = k * NR + r;
          if (!arstn) begin
            valid[k][r] = 1'b0;
          end else begin
            if (acc[k][r]) valid[k][r] = 1'b0;
            if (!valid[k][r] && script_q[q].size() > 0 &&
                !(bubble_en && $urandom_range(3) == 0)) begin
              b = script_q[q].pop_front();
              valid[k][r]         = 1'b1;
              data[k][r*W +: W]   = b.d;
              last[k][r]          = b.l;
              exp_q[q].push_back(b.d);
            end
          end
        end
      end
    end
  end

  // Monitor: samples at negedge, away from the active edge.
  initial begin
    int         ptr   [NK];
    bit         pbusy [NK];
    bit         ppend [NK];
    bit         prel  [NK];
    logic [1:0] pg    [NK];
    logic [1:0] ewin  [NK];
    int         open  [NK];
    int         cur   [NK];
    forever begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        logic [1:0]    g;
        logic [NR-1:0] e_rdy;
        bit newg, rel, found;
        int q, mb;
        g  = gid[k];
        q  = k * NR + int'(g);
        mb = (k == 2) ? 1 : MB;
        if (!arstn) begin
          acc[k] = '0; ptr[k] = 0; pbusy[k] = 0; ppend[k] = 0; prel[k] = 0;
          pg[k] = '0; ewin[k] = '0; open[k] = -1; cur[k] = 0;
        end else begin
          newg = !pbusy[k] && ppend[k];
          if (pbusy[k]) chk("release_rule", busy[k], !prel[k]);
          else          chk("idle_to_grant", busy[k], ppend[k]);
          if (newg) begin
            chk("rr_winner", g, ewin[k]);
            gseq_q[k].push_back(g);
            cur[k]  = 0;
            open[k] = -1;
          end else begin
            chk("grant_hold", g, pg[k]);
          end
          if (pbusy[k] && !busy[k]) begin
            ptr[k] = (int'(pg[k]) + 1) % NR;
            bcnt_q[k].push_back(cur[k]);
          end

          if (busy[k]) begin
            e_rdy = full[k] ? '0 : (NR'(1) << g);
            chk("ready", ready[k], e_rdy);
            chk("wr_en", wr_en[k], valid[k][g] & !full[k]);
          end else begin
            chk("idle_ready", ready[k], 0);
            chk("idle_wr_en", wr_en[k], 0);
          end

          if (wr_en[k]) begin
            chk("beat_has_stimulus", exp_q[q].size() > 0, 1);
            if (exp_q[q].size() > 0) chk("wr_data", wr_data[k], exp_q[q].pop_front());
            log_q[k].push_back(wr_data[k]);
            if (k == 0) begin
              if (open[k] >= 0) chk("pkt_atomic", g, open[k]);
              open[k] = last[k][g] ? -1 : int'(g);
            end
            cur[k]++;
            if (k != 0) chk("burst_limit", cur[k] <= mb, 1);
          end

          rel = 1'b0;
          if (busy[k]) begin
            if (k == 0) rel = wr_en[k] && last[k][g];
            else        rel = (wr_en[k] && cur[k] == mb) || !valid[k][g];
          end
          prel[k]  = rel;
          ppend[k] = !busy[k] && (valid[k] != '0);
          found    = 1'b0;
          ewin[k]  = '0;
          for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (ptr[k] + i) % NR;
            if (!found && valid[k][idx]) begin
              found   = 1'b1;
              ewin[k] = 2'(idx);
            end
          end
          pbusy[k] = busy[k];
          pg[k]    = g;
          acc[k]   = valid[k] & ready[k];
        end
      end
    end
  end

  function automatic bit scripts_empty();
    for (int q = 0; q < NK * NR; q++) if (script_q[q].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int max_cyc, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      #1;
      done = scripts_empty();
      for (int q = 0; q < NK * NR; q++) if (exp_q[q].size() != 0) done = 1'b0;
      for (int k = 0; k < NK; k++) if (valid[k] != '0 || busy[k]) done = 1'b0;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_log(input int k, input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      #1;
      ok = (log_q[k].size() >= n);
    end
    chk(name, ok, 1);
  endtask

  task automatic push_pkt(input int k, input int r, input logic [W-1:0] base, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = base + W'(j);
      b.l = (j == len - 1);
      script_q[k * NR + r].push_back(b);
    end
  endtask

  task automatic flush_all();
    for (int q = 0; q < NK * NR; q++) begin
      script_q[q].delete();
      exp_q[q].delete();
    end
  endtask

  initial begin
    logic [W-1:0] e8;
    beat_t b;
    arstn = 1'b0;
    for (int k = 0; k < NK; k++) full[k] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < NK; k++) begin
      chk("reset_ready", ready[k], 0);
      chk("reset_wr_en", wr_en[k], 0);
      chk("reset_busy", busy[k], 0);
      chk("reset_grant_id", gid[k], 0);
    end
    @(posedge clk);
    #1 arstn = 1'b1;

    // All four requesters offer 2-beat packets together.
    for (int r = 0; r < NR; r++) push_pkt(0, r, 8'hA0 + 8'(r * 16), 2);
    drain(200, "t1_drain");
    chk("t1_count", log_q[0].size(), 8);
    for (int i = 0; i < 8 && i < log_q[0].size(); i++) begin
      e8 = 8'hA0 + 8'((i / 2) * 16) + 8'(i % 2);
      chk("t1_fifo_order", log_q[0][i], e8);
    end
    for (int i = 0; i < 4 && i < gseq_q[0].size(); i++) chk("t1_grant_seq", gseq_q[0][i], i);

    // FIFO full for 5 cycles in the middle of a packet.
    log_q[0].delete();
    push_pkt(0, 2, 8'h20, 4);
    wait_log(0, 1, "t2_first_beat");
    @(posedge clk);
    #1 full[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t2_wr_en_full", wr_en[0], 0);
      chk("t2_ready_full", ready[0], 0);
      chk("t2_grant_full", gid[0], 2);
      chk("t2_busy_full", busy[0], 1);
    end
    @(posedge clk);
    #1 full[0] = 1'b0;
    drain(100, "t2_drain");
    chk("t2_count", log_q[0].size(), 4);
    for (int i = 0; i < 4 && i < log_q[0].size(); i++) chk("t2_data", log_q[0][i], 8'h20 + i);

    // Burst mode: req 1 streams 10 beats while req 2 also wants the port.
    push_pkt(1, 1, 8'h10, 10);
    push_pkt(1, 2, 8'h60, 3);
    drain(200, "t3_drain");
    chk("t3_grants", gseq_q[1].size(), 4);
    for (int i = 0; i < 4 && i < gseq_q[1].size(); i++)
      chk("t3_grant_seq", gseq_q[1][i], (i == 1) ? 2 : 1);
    for (int i = 0; i < 4 && i < bcnt_q[1].size(); i++)
      chk("t3_beats_per_grant", bcnt_q[1][i], (i == 1) ? 3 : (i == 3) ? 2 : 4);

    // MaxBurst=1, only requester 3: every grant wraps the search back to 3.
    push_pkt(2, 3, 8'h30, 6);
    drain(100, "t4_drain");
    chk("t4_grants", gseq_q[2].size(), 6);
    for (int i = 0; i < gseq_q[2].size(); i++) chk("t4_grant_seq", gseq_q[2][i], 3);
    for (int i = 0; i < bcnt_q[2].size(); i++) chk("t4_beats_per_grant", bcnt_q[2][i], 1);

    // Reset after 3 of 5 beats of a packet.
    log_q[0].delete();
    push_pkt(0, 1, 8'h50, 5);
    wait_log(0, 3, "t5_three_beats");
    #1 arstn = 1'b0;
    #1;
    chk("t5_ready_rst", ready[0], 0);
    chk("t5_wr_en_rst", wr_en[0], 0);
    chk("t5_busy_rst", busy[0], 0);
    chk("t5_grant_rst", gid[0], 0);
    repeat (2) @(posedge clk);
    #2 flush_all();
    @(posedge clk);
    #1 arstn = 1'b1;
    gseq_q[0].delete();
    push_pkt(0, 2, 8'h72, 1);
    push_pkt(0, 0, 8'h70, 1);
    drain(100, "t5_drain");
    chk("t5_grants", gseq_q[0].size(), 2);
    if (gseq_q[0].size() >= 2) begin
      chk("t5_first_winner", gseq_q[0][0], 0);
      chk("t5_second_winner", gseq_q[0][1], 2);
    end

    // Random stress: random packets, bubbles and FIFO full on all instances.
    bubble_en = 1'b1;
    for (int q = 0; q < NK * NR; q++) begin
      int n;
      n = 0;
      while (n < 250) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          b.d = 8'($urandom);
          b.l = (j == len - 1);
          script_q[q].push_back(b);
        end
        n += len;
      end
    end
    for (int c = 0; c < 10000 && !scripts_empty(); c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NK; k++) full[k] = ($urandom_range(3) == 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) full[k] = 1'b0;
    drain(20000, "t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
